// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command-decoding system controller:
// opcode values, operand register addresses, FSM state encoding and
// a helper that identifies the states that are waiting for a frame byte.
package sys_ctrl_pkg;

  localparam logic [7:0] OPC_RF_WR   = 8'hAA;
  localparam logic [7:0] OPC_RF_RD   = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_ADDR   = 4'd1,
    ST_WR_DATA   = 4'd2,
    ST_RD_ADDR   = 4'd3,
    ST_RD_WAIT   = 4'd4,
    ST_OPA       = 4'd5,
    ST_OPB       = 4'd6,
    ST_FUN       = 4'd7,
    ST_ALU_START = 4'd8,
    ST_ALU_WAIT  = 4'd9,
    ST_PUSH_RD   = 4'd10,
    ST_PUSH_LO   = 4'd11,
    ST_PUSH_HI   = 4'd12
  } state_e;

  // True for the states that are collecting the next byte of a frame.
  function automatic logic is_collect_state(input state_e s);
    case (s)
      ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
      ST_OPA, ST_OPB, ST_FUN: is_collect_state = 1'b1;
      default:                is_collect_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sys_ctrl_fifo_push.sv
// Single-byte push into the TX FIFO with FIFO_FULL back-pressure.
// done is combinational so the caller can advance in the same cycle the
// push is accepted; the FIFO strobe and data are registered.
module sys_ctrl_fifo_push
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  fifo_wr_inc,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] wr_data_d, wr_data_q;
  logic                  wr_inc_d, wr_inc_q;

  assign done = push_req & ~fifo_full;

  // Next strobe/data: strobe only when the push is accepted, data holds otherwise.
  always_comb begin
    wr_inc_d  = 1'b0;
    wr_data_d = wr_data_q;
    if (done) begin
      wr_inc_d  = 1'b1;
      wr_data_d = push_data;
    end else begin
      wr_inc_d  = 1'b0;
    end
  end

  // Registered FIFO interface.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_inc_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_inc_q  <= wr_inc_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign fifo_wr_inc  = wr_inc_q;
  assign fifo_wr_data = wr_data_q;

endmodule

// File: rtl/sys_ctrl_cmd.sv
// Command-decoding system controller (REF_CLK domain).
// Decodes UART byte frames into RF write/read and ALU operations and
// pushes read/ALU results byte by byte into the TX FIFO.
// Optional build macro CMD_TIMEOUT_EN: abort a frame whose next byte does
// not arrive within TIMEOUT_CYCLES clocks.
module sys_ctrl_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   FIFO_WR_DATA,
  output logic                    FIFO_WR_INC,
  input  logic                    FIFO_FULL,
  output logic                    CMD_ERR
);

  state_e                   state_d, state_q;
  logic [ADDR_WIDTH-1:0]    rf_addr_d, rf_addr_q;
  logic [DATA_WIDTH-1:0]    rf_wr_data_d, rf_wr_data_q;
  logic                     rf_wr_en_d, rf_wr_en_q;
  logic                     rf_rd_en_d, rf_rd_en_q;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_d, alu_fun_q;
  logic                     alu_en_d, alu_en_q;
  logic                     clk_gate_d, clk_gate_q;
  logic                     cmd_err_d, cmd_err_q;
  logic [2*DATA_WIDTH-1:0]  result_d, result_q;

  logic                     push_req_s;
  logic [DATA_WIDTH-1:0]    push_byte_s;
  logic                     push_done_s;
  logic                     tmo_hit_s;

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_d, tmo_cnt_q;

  // Inter-byte gap counter: restarts on every byte, idles outside byte collection.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_hit_s = 1'b0;
    if (RX_D_VLD || !is_collect_state(state_q)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_hit_s = 1'b1;
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Gap counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // Without the timeout the block waits forever; the limit is irrelevant.
  logic unused_tmo_s;
  assign unused_tmo_s = |TIMEOUT_CYCLES;
  assign tmo_hit_s    = 1'b0;
`endif

  // Frame decoder: next state, strobes and latched operands/results.
  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    clk_gate_d   = clk_gate_q;
    result_d     = result_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    cmd_err_d    = 1'b0;
    push_req_s   = 1'b0;
    push_byte_s  = result_q[DATA_WIDTH-1:0];

    if (tmo_hit_s) begin
      // Stalled frame: abandon it; any operand write already issued stands.
      state_d   = ST_IDLE;
      cmd_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              OPC_RF_WR:   state_d = ST_WR_ADDR;
              OPC_RF_RD:   state_d = ST_RD_ADDR;
              OPC_ALU_OP:  state_d = ST_OPA;
              OPC_ALU_NOP: state_d = ST_FUN;
              default:     cmd_err_d = 1'b1;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d   = ST_WR_DATA;
          end else begin
            state_d   = ST_WR_ADDR;
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d      = ST_WR_DATA;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            rf_addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            rf_rd_en_d = 1'b1;
            state_d    = ST_RD_WAIT;
          end else begin
            state_d    = ST_RD_ADDR;
          end
        end
        ST_RD_WAIT: begin
          cmd_err_d = RX_D_VLD;
          if (RF_RD_DATA_VLD) begin
            result_d = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            state_d  = ST_PUSH_RD;
          end else begin
            state_d  = ST_RD_WAIT;
          end
        end
        ST_OPA, ST_OPB: begin
          if (RX_D_VLD) begin
            rf_addr_d    = (state_q == ST_OPA) ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
            rf_wr_data_d = RX_P_DATA;
            rf_wr_en_d   = 1'b1;
            state_d      = (state_q == ST_OPA) ? ST_OPB : ST_FUN;
          end else begin
            state_d      = state_q;
          end
        end
        ST_FUN: begin
          if (RX_D_VLD) begin
            alu_fun_d  = RX_P_DATA[ALU_FUN_WIDTH-1:0];
            clk_gate_d = 1'b1;
            state_d    = ST_ALU_START;
          end else begin
            state_d    = ST_FUN;
          end
        end
        ST_ALU_START: begin
          cmd_err_d = RX_D_VLD;
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
        ST_ALU_WAIT: begin
          cmd_err_d = RX_D_VLD;
          if (ALU_OUT_VLD) begin
            result_d   = ALU_OUT;
            clk_gate_d = 1'b0;
            state_d    = ST_PUSH_LO;
          end else begin
            state_d    = ST_ALU_WAIT;
          end
        end
        ST_PUSH_RD, ST_PUSH_LO: begin
          cmd_err_d   = RX_D_VLD;
          push_req_s  = 1'b1;
          push_byte_s = result_q[DATA_WIDTH-1:0];
          if (push_done_s) begin
            state_d = (state_q == ST_PUSH_RD) ? ST_IDLE : ST_PUSH_HI;
          end else begin
            state_d = state_q;
          end
        end
        ST_PUSH_HI: begin
          cmd_err_d   = RX_D_VLD;
          push_req_s  = 1'b1;
          push_byte_s = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
          if (push_done_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_PUSH_HI;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_fun_q    <= '0;
      alu_en_q     <= 1'b0;
      clk_gate_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_fun_q    <= alu_fun_d;
      alu_en_q     <= alu_en_d;
      clk_gate_q   <= clk_gate_d;
      cmd_err_q    <= cmd_err_d;
      result_q     <= result_d;
    end
  end

  sys_ctrl_fifo_push #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo_push (
    .clk          (CLK),
    .rst          (RST),
    .push_req     (push_req_s),
    .push_data    (push_byte_s),
    .fifo_full    (FIFO_FULL),
    .fifo_wr_data (FIFO_WR_DATA),
    .fifo_wr_inc  (FIFO_WR_INC),
    .done         (push_done_s)
  );

  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = clk_gate_q;
  assign CMD_ERR     = cmd_err_q;

endmodule

// File: doc/sys_ctrl_cmd.md
Name: sys_ctrl_cmd

Overview:
Command-decoding system controller. It consumes byte frames from the UART receiver (after the data synchroniser) and drives the register file and the ALU in the REF_CLK domain. Read results and ALU results are pushed, byte by byte, into the async TX FIFO. It sits between UART_RX/data-sync upstream and RegFile/ALU/FIFO downstream.

Parameters:
DATA_WIDTH, 8, width of a frame byte, RF data and FIFO data
ADDR_WIDTH, 4, RF address width; taken from the low bits of the address byte
ALU_FUN_WIDTH, 4, ALU function code width; taken from the low bits of the FUN byte
TIMEOUT_CYCLES, 200000, allowed inter-byte gap in CLK cycles (only used with CMD_TIMEOUT_EN)

Ports:
CLK  in  1  REF_CLK domain clock
RST  in  1  asynchronous, active-high reset
RX_P_DATA  in  DATA_WIDTH  received byte; valid only when RX_D_VLD=1
RX_D_VLD  in  1  single-cycle byte-valid pulse
RF_ADDR  out  ADDR_WIDTH  RF address
RF_WR_EN  out  1  RF write strobe, one cycle wide
RF_RD_EN  out  1  RF read strobe, one cycle wide
RF_WR_DATA  out  DATA_WIDTH  RF write data
RF_RD_DATA  in  DATA_WIDTH  RF read data
RF_RD_DATA_VLD  in  1  RF read data valid
ALU_FUN  out  ALU_FUN_WIDTH  ALU function code
ALU_EN  out  1  ALU start pulse, one cycle wide
CLK_GATE_EN  out  1  ALU clock-gate enable
ALU_OUT  in  2*DATA_WIDTH  ALU result
ALU_OUT_VLD  in  1  ALU result valid
FIFO_WR_DATA  out  DATA_WIDTH  byte written to the TX FIFO
FIFO_WR_INC  out  1  FIFO push strobe
FIFO_FULL  in  1  FIFO full flag
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset: state goes to IDLE; every output is 0; result registers are cleared. Reset may arrive mid-frame: the frame is aborted and no strobe is issued after RST deasserts.
- Opcodes: 0xAA = RF write (ADDR, DATA); 0xBB = RF read (ADDR); 0xCC = ALU with operands (OPA, OPB, FUN); 0xDD = ALU without operands (FUN).
- Opcode in IDLE that is not one of the above: CMD_ERR pulses for 1 cycle; state stays IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_START, ALU_WAIT, PUSH_RD, PUSH_LO, PUSH_HI.
- Every state transition is driven by RX_D_VLD, except in RD_WAIT, ALU_START, ALU_WAIT and the PUSH states.
- All outputs are registered. A strobe is asserted in the cycle after the RX_D_VLD that completes its field.
- RF write: the DATA byte produces RF_WR_EN=1 with RF_ADDR/RF_WR_DATA, then IDLE.
- RF read:
  - The ADDR byte produces RF_RD_EN=1 for 1 cycle, then RD_WAIT.
  - On RF_RD_DATA_VLD, latch the data and go to PUSH_RD.
- OPA byte: RF write to address 0. OPB byte: RF write to address 1. 0xDD goes straight to FUN.
- FUN byte:
  - Next cycle: ALU_FUN is latched and CLK_GATE_EN=1.
  - Following cycle (ALU_START): ALU_EN pulses for 1 cycle.
  - ALU_WAIT: on ALU_OUT_VLD, latch ALU_OUT and drop CLK_GATE_EN the next cycle.
  - Then PUSH_LO and PUSH_HI.
- Pushing: in a PUSH state, if FIFO_FULL=0, FIFO_WR_INC=1 for 1 cycle with the byte, then advance.
  - If FIFO_FULL=1, hold the state with no strobe.
  - PUSH_RD and PUSH_HI return to IDLE.
- RX_D_VLD arriving in RD_WAIT, ALU_START, ALU_WAIT or a PUSH state: the byte is dropped and CMD_ERR pulses.
- RF_RD_DATA_VLD or ALU_OUT_VLD outside its wait state: ignored.
- Widths: the address byte is truncated to ADDR_WIDTH and the FUN byte to ALU_FUN_WIDTH; upper bits are ignored.

Optional Feature:
CMD_TIMEOUT_EN
- Defined:
  - A counter clears on each RX_D_VLD and counts in the byte-collecting states (WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN).
  - On reaching TIMEOUT_CYCLES the frame is aborted: CMD_ERR pulses, state returns to IDLE, and no RF/ALU strobe is issued.
  - A write already committed (e.g. OPA) is not undone.
- Undefined: no counter; the block waits indefinitely for the next byte.

Decomposition:
- Package sys_ctrl_pkg holds:
  - the opcode constants (0xAA, 0xBB, 0xCC, 0xDD);
  - the operand RF addresses (OPA_ADDR=0, OPB_ADDR=1);
  - the state enum.
- One sub-module, sys_ctrl_fifo_push: a byte push with FIFO_FULL back-pressure. It takes a request plus a byte and returns done. It is used for all three PUSH states.

Test Plan:
- Frame AA 05 3C -> one RF_WR_EN pulse with RF_ADDR=5 and RF_WR_DATA=0x3C; no FIFO push.
- Frame BB 05, bench returns RF_RD_DATA=0x3C after 1 cycle -> RF_RD_EN pulse with addr 5, then one FIFO_WR_INC with 0x3C.
- Frame CC 0A 03 00, bench ALU returns 0x000D -> RF writes (0,0x0A) then (1,0x03), CLK_GATE_EN high, ALU_FUN=0, ALU_EN one cycle after the gate, then FIFO bytes 0x0D then 0x00.
- Frame DD 02 with FIFO_FULL held high for 20 cycles, ALU_OUT=0x0102 -> no FIFO_WR_INC while full; afterwards 0x02 then 0x01; no RF writes.
- Byte 0x55 in IDLE -> CMD_ERR pulse, state stays IDLE; a following AA 01 FF executes normally.
- RST asserted after AA 05 -> no RF_WR_EN; all outputs 0. With CMD_TIMEOUT_EN: BB followed by silence -> CMD_ERR after TIMEOUT_CYCLES and no RF_RD_EN.
